// File: rtl/spi_pkg.sv
// Shared SPI definitions: sequencer state encoding, mode bit positions and
// the mode type used by the master FSM, the clock generator and the shifter.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef logic [1:0] spi_mode_t;

endpackage

// File: rtl/spi_sclk_gen_if.sv
// Control/strobe bundle between the SPI master FSM, the serial-clock
// sequencer and the shift register.
interface spi_sclk_gen_if
  import spi_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 5
);
  logic              start;
  logic              stop;
  logic [DIV_W-1:0]  div;
  spi_mode_t         mode;
  logic [BITS_W-1:0] len;
  logic              sclk;
  logic              rise;
  logic              fall;
  logic              sample;
  logic              shift;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, div, mode, len,
    input  sclk, rise, fall, sample, shift, busy, done
  );

  modport slave (
    input  start, stop, div, mode, len,
    output sclk, rise, fall, sample, shift, busy, done
  );
endinterface

// File: rtl/spi_half_div.sv
// Half-period counter: holds the latched divisor and counts 0..div_q while
// enabled, flagging the terminal count with a combinational tick.
module spi_half_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  // Terminal count is compared against div_q, so the all-ones divisor never overflows
  assign tick = en && (cnt == div_q);

  // Latch the divisor once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_q <= '0;
    else if (load) div_q <= div;
  end

  // Count one half-period, wrapping to zero on the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock and frame sequencer: runtime divisor, all four CPOL/CPHA
// modes, self-timed burst of len+1 bits with sample/shift strobes and abort.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_sclk_gen_if.slave bus
);

  state_t            state, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [BITS_W-1:0] len_q, len_d;
  logic [BITS_W:0]   ec, ec_d;
  logic              sclk_q, sclk_d;
  logic              rise_q, rise_d, fall_q, fall_d;
  logic              sample_q, sample_d, shift_q, shift_d;
  logic              done_q, done_d;
  logic              hd_en, hd_clear, hd_load, tick;
  logic              last_edge, leading;

  spi_half_div #(.DIV_W(DIV_W)) u_half_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hd_en),
    .clear (hd_clear),
    .load  (hd_load),
    .div   (bus.div),
    .tick  (tick)
  );

  // ec holds edges already made, so the upcoming edge is ec+1; edge E is the
  // last one and E-1 = 2*len_q+1 always fits in BITS_W+1 bits
  assign last_edge = (ec == {len_q, 1'b1});
  assign leading   = ~ec[0];

  // Next-state, counter and strobe decode
  always_comb begin
    state_d  = state;
    mode_d   = mode_q;
    len_d    = len_q;
    ec_d     = ec;
    sclk_d   = sclk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    done_d   = 1'b0;
    hd_en    = 1'b0;
    hd_clear = 1'b0;
    hd_load  = 1'b0;
    case (state)
      IDLE: begin
        sclk_d = bus.mode[CPOL_BIT];
        if (bus.start && !bus.stop) begin
          state_d  = RUN;
          mode_d   = bus.mode;
          len_d    = bus.len;
          ec_d     = '0;
          hd_clear = 1'b1;
          hd_load  = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d  = IDLE;
          sclk_d   = mode_q[CPOL_BIT];
          ec_d     = '0;
          hd_clear = 1'b1;
        end else begin
          hd_en = 1'b1;
          if (tick) begin
            sclk_d = ~sclk_q;
            rise_d = ~sclk_q;
            fall_d = sclk_q;
            ec_d   = ec + 1'b1;
            if (mode_q[CPHA_BIT]) begin
              shift_d  = leading;
              sample_d = ~leading;
            end else begin
              sample_d = leading;
              shift_d  = ~leading && !last_edge;
            end
            if (last_edge) begin
              state_d = TAIL;
              ec_d    = '0;
            end
          end
        end
      end
      TAIL: begin
        if (bus.stop) begin
          state_d  = IDLE;
          sclk_d   = mode_q[CPOL_BIT];
          hd_clear = 1'b1;
        end else begin
          hd_en = 1'b1;
          if (tick) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, edge counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ec       <= '0;
      sclk_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      ec       <= ec_d;
      sclk_q   <= sclk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end

  // Frame configuration, captured on an accepted start
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    len_q  <= len_d;
  end

  assign bus.sclk   = sclk_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
  assign bus.sample = sample_q;
  assign bus.shift  = shift_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: directed and randomized frames compared cycle by
// cycle against an arithmetic timing model of the frame.
module tb_spi_sclk_gen;

  localparam int DIV_W  = 8;
  localparam int BITS_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sclk_gen_if #(.DIV_W(DIV_W), .BITS_W(BITS_W)) bus ();

  spi_sclk_gen #(.DIV_W(DIV_W), .BITS_W(BITS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic sclk, rise, fall, sample, shift, busy, done;
  } obs_t;

  function automatic obs_t observe();
    return obs_t'({bus.sclk, bus.rise, bus.fall, bus.sample, bus.shift, bus.busy, bus.done});
  endfunction

  function automatic obs_t idle_exp(input int m);
    obs_t r = '0;
    r.sclk = m[1];
    return r;
  endfunction

  // Expected outputs n cycles after the cycle in which start was sampled
  function automatic obs_t model(input int n, input int d, input int m, input int len);
    obs_t r = '0;
    int p, e, nd, edges, k;
    p  = d + 1;
    e  = 2 * (len + 1);
    nd = 1 + (e + 1) * p;
    if (n >= nd) begin
      r.done = 1'b1;
      r.sclk = m[1];
      return r;
    end
    r.busy = 1'b1;
    edges = (n - 1) / p;
    if (edges > e) edges = e;
    r.sclk = m[1] ^ edges[0];
    if (((n - 1) % p == 0) && ((n - 1) / p >= 1) && ((n - 1) / p <= e)) begin
      k = (n - 1) / p;
      r.rise = r.sclk;
      r.fall = ~r.sclk;
      if (m[0]) begin
        r.shift  = k[0];
        r.sample = ~k[0];
      end else begin
        r.sample = k[0];
        r.shift  = ~k[0] && (k != e);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed sclk/rise/fall/sample/shift/busy/done=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive_cfg(input int d, input int m, input int len);
    bus.div  = DIV_W'(d);
    bus.mode = 2'(m);
    bus.len  = BITS_W'(len);
  endtask

  // Called at a negedge; start is asserted in this cycle. Returns at the
  // negedge of the done cycle (or of the last checked cycle).
  task automatic frame(input int d, input int m, input int len,
                       input int stop_at, input bit noise, input int cut);
    int p, nd, last;
    obs_t exp;
    p  = d + 1;
    nd = 1 + (2 * (len + 1) + 1) * p;
    drive_cfg(d, m, len);
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    last = (stop_at > 0) ? stop_at + 3 * p + 2 : nd;
    if (cut > 0 && cut < last) last = cut;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (stop_at > 0 && n > stop_at) exp = idle_exp(m);
      else                            exp = model(n, d, m, len);
      chk($sformatf("frame_d%0d_m%0d_l%0d_n%0d", d, m, len, n), observe(), exp);
      bus.start = 1'b0;
      bus.stop  = (stop_at > 0 && n == stop_at);
      if (noise && n < nd - 1) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.div   = DIV_W'($urandom);
        bus.len   = BITS_W'($urandom);
        bus.mode  = 2'($urandom);
      end else begin
        drive_cfg(d, m, len);
      end
    end
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk($sformatf("idle_%0d", i), observe(), idle_exp(int'(bus.mode)));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    drive_cfg(0, 3, 0);

    // Reset values, then sclk follows mode[1] from the first edge after release
    #2;
    chk("reset_values", observe(), '0);
    @(negedge clk);
    chk("reset_held", observe(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_sclk_cpol", observe(), idle_exp(3));
    bus.mode = 2'd0;
    idle(2);

    // Mode 0, div 0, len 7
    frame(0, 0, 7, 0, 1'b0, 0);
    bus.mode = 2'd3;
    idle(2);

    // Mode 3, div 3, len 0
    frame(3, 3, 0, 0, 1'b0, 0);
    idle(2);

    // Mode 1, div 1, len 3
    frame(1, 1, 3, 0, 1'b0, 0);
    idle(1);

    // Abort after edge 5 (edge 5 lands at n = 1 + 5*3 = 16)
    frame(2, 0, 7, 17, 1'b0, 0);

    // start together with stop in IDLE is ignored
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    chk("start_with_stop_idle", observe(), idle_exp(0));
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    idle(1);

    // Noise while busy, then a back-to-back start in the done cycle
    frame(0, 0, 3, 0, 1'b1, 0);
    frame(0, 0, 3, 0, 1'b0, 0);
    idle(2);

    // Randomized frames, some back-to-back, some with noise
    for (int i = 0; i < 8; i++) begin
      frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
            0, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    // Asynchronous reset mid-frame
    frame(1, 2, 5, 0, 1'b0, 8);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_mid_frame", observe(), '0);
    @(negedge clk);
    chk("async_reset_held", observe(), '0);
    bus.mode = 2'd0;
    rst_n = 1'b1;
    idle(2);

    // Widest divisor and longest frame
    frame(255, 0, 31, 0, 1'b0, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

Parametrised SPI serial-clock and frame sequencer for the SPI master, the next generation of the fixed-table baud generator. It provides a runtime-programmable divisor of any width, all four CPOL/CPHA modes, and a self-timed burst of a programmed number of bits. It emits per-edge strobes telling the shifter when to sample and when to shift, plus busy/done handshakes and abort. It sits between the master control FSM and the shift register.

## Interface
Parameters:
- DIV_W, 8: width of the half-period divisor.
- BITS_W, 5: width of the frame-length field; the longest frame is 2^BITS_W bits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- stop  in  1  abort; honoured in RUN/TAIL.
- div  in  DIV_W  half-period minus one; each SCLK half-period lasts div+1 clk cycles.
- mode  in  2  SPI mode; mode[1]=CPOL, mode[0]=CPHA.
- len  in  BITS_W  frame length minus one; a frame is len+1 bits.
- sclk  out  1  SPI clock, registered.
- rise  out  1  one-cycle pulse in the first cycle sclk shows 1 after a 0.
- fall  out  1  one-cycle pulse in the first cycle sclk shows 0 after a 1.
- sample  out  1  one-cycle pulse: the shifter captures MISO.
- shift  out  1  one-cycle pulse: the shifter advances MOSI.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse when a frame completes normally.

## Operation
- States are IDLE, RUN and TAIL.
- IDLE:
  - sclk is loaded with mode[1] every cycle.
  - start with stop low latches div, mode and len into div_q, mode_q and len_q, clears both counters, then goes to RUN.
  - If start and stop are high together, stop wins and start is ignored.
- RUN:
  - The half-period counter hc counts 0..div_q.
  - When hc==div_q: sclk toggles, hc clears, and the edge counter ec increments.
  - The frame has E = 2*(len_q+1) edges, numbered 1..E. ec is BITS_W+1 bits wide.
  - Odd edges are leading, even edges are trailing.
  - CPHA=0: sample on every leading edge; shift on trailing edges 2..E-2 (len_q pulses).
  - CPHA=1: shift on every leading edge; sample on every trailing edge.
  - After edge E, go to TAIL. sclk is back at CPOL.
- TAIL: wait one more half-period (div_q+1 cycles), then pulse done and go to IDLE.
- stop in RUN/TAIL:
  - Next cycle: IDLE, sclk=mode_q[1], all counters cleared.
  - No done and no further pulses.
- start while busy is ignored.
- Changes to div, mode or len while busy have no effect.
- rise/fall follow the actual sclk level. sample/shift are CPOL-independent.

## Timing
- Reset values: sclk=0, rise=fall=sample=shift=0, busy=0, done=0, state IDLE, hc=ec=0.
- An asynchronous reset mid-frame forces all of the above immediately.
- After reset, sclk follows mode[1] from the first clock edge.
- Start sampled at cycle t gives busy=1 from cycle t+1.
- Edge k (1..E): the new sclk level and the rise/fall/sample/shift pulses appear together in cycle t+1+k*(div_q+1).
- Done appears in cycle t+1+(E+1)*(div_q+1). busy=0 in that same cycle.
- A new start is accepted in the done cycle, giving busy again the next cycle.
- div=0: sclk = clk/2. div=2^DIV_W-1: half-period = 2^DIV_W cycles, with no counter overflow.
- len=2^BITS_W-1 gives E=2^(BITS_W+1); ec must not wrap before edge E.

## Structure
- Shared package spi_pkg:
  - State encoding: IDLE/RUN/TAIL.
  - CPOL_BIT=1 and CPHA_BIT=0 index constants.
  - The SPI mode type shared with the master FSM and the shifter.
- Sub-module spi_half_div: a DIV_W half-period counter with en, clear and load, producing a terminal tick.
- The FSM, edge counter and strobe decode stay in spi_sclk_gen.

## Test plan
- Mode 0, div=0, len=7, start at t: busy from t+1; 8 rise and 8 sample pulses; 7 shift pulses; sclk toggles every cycle from t+2; done at t+18; sclk ends 0.
- Mode 3, div=3, len=0: sclk idles 1; edges at t+5 (fall, shift) and t+9 (rise, sample); done at t+13.
- Mode 1, div=1, len=3: 4 shift pulses on rising edges, 4 sample pulses on falling edges; done at t+1+9*2=t+19.
- Mode 0, div=2, len=7: stop asserted mid-frame after edge 5 gives busy=0 next cycle, sclk=0, no done, no further pulses. A start in the same cycle as stop in IDLE is ignored.
- rst_n dropped asynchronously mid-frame: all outputs at reset values before the next clk edge. After release, a new frame with div=255, len=31 has a half-period of 256 cycles and 64 edges, and done at t+1+65*256.
- Mode 0, div=0, len=3: start pulses while busy, plus div/len changes while busy, have no effect on the frame. A back-to-back start in the done cycle is accepted.
